// File: rtl/ram_rd_check.sv
// rtl/ram_rd_check.sv - port-B read sweep checker for the dual-port RAM test path
module ram_rd_check #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 128,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] seed,
  output logic              ram_en_b,
  output logic [ADDR_W-1:0] ram_addr_b,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   err_cnt,
  output logic [ADDR_W-1:0] first_err_addr
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  localparam int DW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
  localparam logic [DW-1:0]     DRAIN_LAST = DW'(RD_LAT - 1);

  state_t                         r_state, w_state_nxt;
  logic [DATA_W-1:0]              r_seed;
  logic                           r_en;
  logic [ADDR_W-1:0]              r_addr;
  logic                           r_busy, r_done, r_pass, r_first_seen;
  logic [ADDR_W:0]                r_err;
  logic [ADDR_W-1:0]              r_first;
  logic [DW-1:0]                  r_drain_cnt;
  logic [RD_LAT-1:0]              r_pv;
  logic [RD_LAT-1:0][ADDR_W-1:0]  r_pa;

  logic [ADDR_W-1:0]        w_cmp_addr;
  logic [DATA_W+ADDR_W-1:0] w_addr_ext;
  logic [DATA_W-1:0]        w_exp;
  logic                     w_mis;
  logic [ADDR_W:0]          w_err_nxt;

  assign ram_en_b       = r_en;
  assign ram_addr_b     = r_addr;
  assign busy           = r_busy;
  assign done           = r_done;
  assign pass           = r_pass;
  assign err_cnt        = r_err;
  assign first_err_addr = r_first;

  // The oldest pipe stage lines up with the word now on ram_rd_data.
  assign w_cmp_addr = r_pa[RD_LAT-1];
  assign w_addr_ext = {{DATA_W{1'b0}}, w_cmp_addr};
  assign w_exp      = w_addr_ext[DATA_W-1:0] + r_seed;
  assign w_mis      = r_pv[RD_LAT-1] && (ram_rd_data != w_exp);
  assign w_err_nxt  = (w_mis && !(&r_err)) ? r_err + (ADDR_W+1)'(1) : r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_READ;
      S_READ:  if (r_addr == LAST_ADDR) w_state_nxt = S_DRAIN;
      S_DRAIN: if (r_drain_cnt == DRAIN_LAST) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seed       <= '0;
      r_en         <= 1'b0;
      r_addr       <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_first_seen <= 1'b0;
      r_err        <= '0;
      r_first      <= '0;
      r_drain_cnt  <= '0;
      r_pv         <= '0;
      r_pa         <= '0;
    end else begin
      r_pv[0] <= r_en;
      r_pa[0] <= r_addr;
      for (int i = 1; i < RD_LAT; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pa[i] <= r_pa[i-1];
      end
      r_done <= (w_state_nxt == S_DONE);

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_seed       <= seed;
            r_err        <= '0;
            r_pass       <= 1'b0;
            r_first      <= '0;
            r_first_seen <= 1'b0;
            r_busy       <= 1'b1;
            r_en         <= 1'b1;
            r_addr       <= '0;
          end
        end
        S_READ: begin
          if (r_addr == LAST_ADDR) begin
            r_en   <= 1'b0;
            r_addr <= '0;
          end else begin
            r_addr <= r_addr + ADDR_W'(1);
          end
        end
        S_DRAIN: r_drain_cnt <= (r_drain_cnt == DRAIN_LAST) ? '0 : r_drain_cnt + DW'(1);
        S_DONE:  r_busy <= 1'b0;
        default: ;
      endcase

      // Compares run only while a sweep is active so the start-time clear is not overwritten.
      if (r_state != S_IDLE) begin
        r_err <= w_err_nxt;
        if (w_mis && !r_first_seen) begin
          r_first      <= w_cmp_addr;
          r_first_seen <= 1'b1;
        end
      end
      if (r_state == S_DRAIN && w_state_nxt == S_DONE)
        r_pass <= (w_err_nxt == '0);
    end
  end

endmodule

// File: tb/tb_ram_rd_check.sv
// tb/tb_ram_rd_check.sv - bench for ram_rd_check at read latencies 1 and 3
module tb_ram_rd_check;

  logic       clk = 1'b0;
  logic       rst_n, start;
  logic [7:0] seed;
  logic       en1, busy1, done1, pass1, en3, busy3, done3, pass3;
  logic [6:0] addr1, first1, addr3, first3;
  logic [7:0] rd1, rd3, err1, err3;

  logic [7:0] mem [128];
  logic [7:0] junk;
  logic       m1v;
  logic [6:0] m1a;
  logic [2:0] m3v;
  logic [2:0][6:0] m3a;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0] fill;
    int         c1;
    int         c2;
    logic [7:0] sd;
    bit         pass;
    int         err;
    int         first;
  } vec_t;

  typedef struct {
    bit pass;
    int err;
    int first;
    int done_cyc;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];
  vec_t vecs[4];

  always #5 clk = ~clk;

  ram_rd_check #(.ADDR_W(7), .DATA_W(8), .DEPTH(128), .RD_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .seed(seed),
    .ram_en_b(en1), .ram_addr_b(addr1), .ram_rd_data(rd1),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1), .first_err_addr(first1)
  );

  ram_rd_check #(.ADDR_W(7), .DATA_W(8), .DEPTH(128), .RD_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .seed(seed),
    .ram_en_b(en3), .ram_addr_b(addr3), .ram_rd_data(rd3),
    .busy(busy3), .done(done3), .pass(pass3), .err_cnt(err3), .first_err_addr(first3)
  );

  // RAM model: data valid RD_LAT cycles after the enabled address, garbage otherwise.
  always @(negedge clk) junk = 8'($urandom);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m1v <= 1'b0; m1a <= '0; m3v <= '0; m3a <= '0;
    end else begin
      m1v <= en1; m1a <= addr1;
      m3v <= {m3v[1:0], en3};
      m3a <= {m3a[1:0], addr3};
    end
  end

  assign rd1 = m1v    ? mem[m1a]    : junk;
  assign rd3 = m3v[2] ? mem[m3a[2]] : junk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fill_mem(input logic [7:0] off, input int c1, input int c2);
    for (int a = 0; a < 128; a++) mem[a] = 8'(a) + off;
    if (c1 >= 0) mem[c1] = 8'hFF;
    if (c2 >= 0) mem[c2] = 8'h00;
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_dut1"}, int'({en1, addr1, busy1, done1, pass1, err1, first1}), 0);
    chk({name, "_dut3"}, int'({en3, addr3, busy3, done3, pass3, err3, first3}), 0);
  endtask

  task automatic run_sweep(input logic [7:0] sd, input bit ep, input int ee, input int ef,
                           input int restart_cyc);
    int   k, bad;
    bit   got1, got3;
    exp_t e;
    @(negedge clk);
    seed  = sd;
    start = 1'b1;
    q1.push_back('{ep, ee, ef, 130});
    q3.push_back('{ep, ee, ef, 132});
    @(negedge clk);
    start = 1'b0;
    k = 1; bad = 0; got1 = 0; got3 = 0;
    while (!(got1 && got3) && k < 400) begin
      start = (k == restart_cyc);
      if (k == restart_cyc) seed = 8'h55;
      if (k == 1) begin
        chk("busy_c1", int'({busy1, busy3}), 3);
        chk("cleared_c1", int'({pass1, err1, pass3, err3}), 0);
      end
      if (en1 !== (k <= 128) || addr1 !== ((k <= 128) ? 7'(k - 1) : 7'd0)) bad++;
      if (en3 !== (k <= 128) || addr3 !== ((k <= 128) ? 7'(k - 1) : 7'd0)) bad++;
      if (done1 && !got1) begin
        got1 = 1;
        if (q1.size() > 0) begin
          e = q1.pop_front();
          chk("done_cycle1", k, e.done_cyc);
          chk("pass1", int'(pass1), int'(e.pass));
          chk("err_cnt1", int'(err1), e.err);
          chk("first_err1", int'(first1), e.first);
        end
      end
      if (done3 && !got3) begin
        got3 = 1;
        if (q3.size() > 0) begin
          e = q3.pop_front();
          chk("done_cycle3", k, e.done_cyc);
          chk("pass3", int'(pass3), int'(e.pass));
          chk("err_cnt3", int'(err3), e.err);
          chk("first_err3", int'(first3), e.first);
        end
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    chk("done_seen", int'({got1, got3}), 3);
    chk("addr_seq", bad, 0);
    chk("busy_after", int'({busy1, busy3}), 0);
    q1.delete();
    q3.delete();
  endtask

  initial begin
    int dn;
    vecs[0] = '{8'h00, -1, -1, 8'h00, 1'b1, 0,   0};
    vecs[1] = '{8'h00, 37, 90, 8'h00, 1'b0, 2,   37};
    vecs[2] = '{8'hF0, -1, -1, 8'hF0, 1'b1, 0,   0};
    vecs[3] = '{8'hF0, -1, -1, 8'h00, 1'b0, 128, 0};

    rst_n = 1'b0; start = 1'b0; seed = 8'h00;
    fill_mem(8'h00, -1, -1);
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset_state");
    rst_n = 1'b1;

    for (int v = 0; v < 4; v++) begin
      fill_mem(vecs[v].fill, vecs[v].c1, vecs[v].c2);
      run_sweep(vecs[v].sd, vecs[v].pass, vecs[v].err, vecs[v].first, -1);
    end

    // Second start mid-sweep must be ignored.
    fill_mem(8'h00, -1, -1);
    run_sweep(8'h00, 1'b1, 0, 0, 50);

    // Asynchronous reset mid-sweep abandons the sweep.
    fill_mem(8'h00, 37, -1);
    @(negedge clk);
    seed = 8'h00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (59) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("reset_midsweep");
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    repeat (150) begin
      @(negedge clk);
      if (done1 || done3) dn++;
    end
    chk("no_done_after_reset", dn, 0);

    fill_mem(8'h00, -1, -1);
    run_sweep(8'h00, 1'b1, 0, 0, -1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ram_rd_check.md
Name: ram_rd_check

Overview:
Read-side checker for the on-chip dual-port RAM test path. After the port-A writer has filled the RAM with an incrementing pattern, this block sweeps port B over every address. It compares each returned word against the expected value (address + seed) and reports a pass/fail verdict, an error count and the first failing address. The outputs are suitable for LED or ILA observation.

Parameters:
ADDR_W, 7, port-B address width
DATA_W, 8, RAM data width
DEPTH, 128, number of words swept (1..2^ADDR_W)
RD_LAT, 1, RAM read latency in clk cycles (1..4)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse; begins a sweep; accepted only in IDLE
seed  in  DATA_W  pattern offset; sampled on the accepted start
ram_en_b  out  1  port-B enable
ram_addr_b  out  ADDR_W  port-B read address
ram_rd_data  in  DATA_W  port-B read data
busy  out  1  sweep in progress
done  out  1  one-cycle pulse at end of sweep
pass  out  1  verdict; valid from done until next accepted start
err_cnt  out  ADDR_W+1  mismatch count, saturating at all-ones
first_err_addr  out  ADDR_W  address of first mismatch in current sweep

Behaviour:
- Interface: reset rst_n, asynchronous, active-low; clock clk. All outputs are registered.
- Reset values: ram_en_b=0, ram_addr_b=0, busy=0, done=0, pass=0, err_cnt=0, first_err_addr=0, state=IDLE, seed register=0, latency pipe cleared.
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE -> READ: on start=1 at an edge (E0).
  - Capture seed.
  - Clear err_cnt, pass and first_err_addr, and the internal first-error flag.
  - Set busy=1, ram_en_b=1, ram_addr_b=0.
- READ:
  - Cycle k (k=1..DEPTH after E0) presents address k-1 with ram_en_b=1.
  - The address increments by 1 each cycle.
  - After address DEPTH-1 is presented: go to DRAIN, ram_en_b=0, ram_addr_b=0.
- Latency pipe: an RD_LAT-deep shift register carries {valid, addr}.
  - An address issued in cycle n has its data on ram_rd_data during cycle n+RD_LAT.
  - That data is compared at the edge closing cycle n+RD_LAT.
- DRAIN: stay exactly RD_LAT cycles so the last word is compared, then go to DONE.
- DONE (one cycle):
  - done=1.
  - pass=1 if and only if err_cnt==0, including the final compare.
  - busy remains 1 during this cycle.
  - Next state is IDLE, where done=0 and busy=0.
- Timing: with DEFAULTS, start at E0 gives done high in cycle DEPTH+RD_LAT+1 = 130.
- Expected value: (addr + seed) mod 2^DATA_W, using zero-extended addr truncated to DATA_W.
- Mismatch handling:
  - Increment err_cnt, saturating at all-ones.
  - If this is the first mismatch of the sweep, load first_err_addr with that address; the value holds until the next accepted start.
- Ignored start: start during READ, DRAIN or DONE is ignored and not queued.
- ram_rd_data is ignored whenever the pipe valid bit is 0.
- Reset mid-sweep: all state and outputs return to reset values immediately; the sweep is abandoned and no done is produced.
- pass, err_cnt and first_err_addr hold after done until the next accepted start.

Test Plan:
- Model RAM holds addr+0 for all 128 words, RD_LAT=1, seed=0, start pulse -> addresses 0..127 presented in cycles 1..128; done in cycle 130; pass=1, err_cnt=0.
- RAM word at addr 37 corrupted to 0xFF, plus addr 90 corrupted -> pass=0, err_cnt=2, first_err_addr=37.
- seed=0xF0 with RAM holding (addr+0xF0) mod 256 -> pass=1, confirming data wrap at 255->0. Repeat with seed=0 -> err_cnt=128, no counter overflow.
- RD_LAT=3 build, clean RAM -> done in cycle 132, pass=1. Inject garbage on ram_rd_data while no compare is due -> no effect.
- start re-pulsed in cycle 50 of a sweep -> ignored; addresses stay contiguous and exactly one done. Back-to-back start after done -> new sweep clears err_cnt.
- rst_n low in cycle 60 -> all outputs 0 asynchronously and no done. After release, a fresh start runs a full clean sweep to pass=1.
